// File: rtl/esm_pkg.sv
// ESM issue queue shared definitions.
// Field positions, entry states and the pairwise hazard test.
package esm_pkg;

   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int FW      = 5;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      WAIT   = 2'd1,
      ISSUED = 2'd2
   } esm_state_e;

   typedef struct packed {
      logic          regwr;
      logic          alusrc;
      logic [FW-1:0] rd;
      logic [FW-1:0] rs1;
      logic [FW-1:0] rs2;
   } esm_fields_t;

   // RAW | WAR | WAW between an older and a younger entry
   function automatic logic esm_conflict(input esm_fields_t older,
                                         input esm_fields_t younger);
      logic raw, war, waw;
      raw = older.regwr &&
            (older.rd == younger.rs1 ||
             (!younger.alusrc && older.rd == younger.rs2));
      war = younger.regwr &&
            (younger.rd == older.rs1 ||
             (!older.alusrc && younger.rd == older.rs2));
      waw = older.regwr && younger.regwr &&
            older.rd == younger.rd;
      return raw | war | waw;
   endfunction

endpackage

// File: rtl/esm_prio_pick.sv
// K-way lowest-index picker.
// Grant k is the (k+1)-th lowest set request bit, one-hot.
module esm_prio_pick #(
   parameter int N = 16,
   parameter int K = 2
) (
   input  logic [N-1:0]        req,
   output logic [K-1:0][N-1:0] gnt,
   output logic [K-1:0]        vld
);

   logic [N-1:0] rem;

   // peel off the lowest remaining request once per slot
   always_comb begin
      rem = req;
      gnt = '0;
      vld = '0;
      for (int k = 0; k < K; k++) begin
         gnt[k] = rem & (~rem + N'(1));
         vld[k] = |rem;
         rem    = rem & ~gnt[k];
      end
   end

endmodule

// File: rtl/esm_issue_queue.sv
// ESM issue queue: hazard-tracked buffer issuing
// up to ISSUE_W independent instructions per cycle.
module esm_issue_queue
   import esm_pkg::*;
#(
   parameter int IW      = 32,
   parameter int BS      = 16,
   parameter int REGNUM  = 16,
   parameter int ISSUE_W = 2,
   localparam int TW     = $clog2(BS),
   localparam int RB     = $clog2(REGNUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IW-1:0]         in_instr,
   input  logic                  in_regwr,
   input  logic                  in_alusrc,
   output logic [ISSUE_W-1:0]    iss_valid,
   input  logic [ISSUE_W-1:0]    iss_ready,
   output logic [ISSUE_W*IW-1:0] iss_instr,
   output logic [ISSUE_W*TW-1:0] iss_tag,
   input  logic                  cmp_valid,
   input  logic [TW-1:0]         cmp_tag,
   output logic [TW:0]           occupancy,
   output logic                  err
);

   esm_state_e  st    [BS];
   logic [IW-1:0] ins [BS];
   esm_fields_t fld   [BS];
   logic [BS-1:0] older [BS];

   logic [TW:0]   occ;
   logic [BS-1:0] live;
   logic [BS-1:0] rdy;
   logic [BS-1:0] cmp_mask;
   logic [TW-1:0] aidx;
   logic [TW-1:0] tag [ISSUE_W];
   logic          alloc;
   logic          cmp_ok;
   logic          blk;

   logic [ISSUE_W-1:0][BS-1:0] gnt;
   logic [ISSUE_W-1:0]         gv;

   function automatic esm_fields_t decode(input logic [IW-1:0] w,
                                          input logic rw,
                                          input logic as);
      esm_fields_t f;
      f             = '0;
      f.regwr       = rw;
      f.alusrc      = as;
      f.rd[RB-1:0]  = w[RD_LSB +: RB];
      f.rs1[RB-1:0] = w[RS1_LSB +: RB];
      f.rs2[RB-1:0] = w[RS2_LSB +: RB];
      return f;
   endfunction

   // an entry is ready when waiting and no live older entry conflicts
   always_comb begin
      blk = 1'b0;
      for (int i = 0; i < BS; i++)
         live[i] = (st[i] != FREE);
      for (int i = 0; i < BS; i++) begin
         blk = 1'b0;
         for (int j = 0; j < BS; j++)
            if (older[i][j] && live[j] &&
                esm_conflict(fld[j], fld[i]))
               blk = 1'b1;
         rdy[i] = (st[i] == WAIT) && !blk;
      end
   end

   // allocation target and completion qualification
   always_comb begin
      aidx = '0;
      for (int i = BS - 1; i >= 0; i--)
         if (st[i] == FREE)
            aidx = TW'(i);
      in_ready  = occ < (TW+1)'(BS);
      alloc     = in_valid && in_ready;
      cmp_ok    = cmp_valid && (st[cmp_tag] == ISSUED);
      cmp_mask  = cmp_ok ? (BS'(1) << cmp_tag) : '0;
      occupancy = occ;
   end

   esm_prio_pick #(
      .N (BS),
      .K (ISSUE_W)
   ) u_pick (
      .req (rdy),
      .gnt (gnt),
      .vld (gv)
   );

   // turn one-hot grants into slot tags and instructions
   always_comb begin
      iss_valid = gv;
      iss_tag   = '0;
      iss_instr = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         tag[k] = '0;
         for (int i = 0; i < BS; i++)
            if (gnt[k][i])
               tag[k] = tag[k] | TW'(i);
         iss_tag[k*TW +: TW] = tag[k];
         if (gv[k])
            iss_instr[k*IW +: IW] = ins[tag[k]];
      end
   end

   // entry states, age matrix, occupancy and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BS; i++) begin
            st[i]    <= FREE;
            older[i] <= '0;
         end
         occ <= '0;
         err <= 1'b0;
      end else begin
         for (int k = 0; k < ISSUE_W; k++)
            if (gv[k] && iss_ready[k])
               st[tag[k]] <= ISSUED;
         if (cmp_valid) begin
            if (cmp_ok) begin
               st[cmp_tag] <= FREE;
               for (int x = 0; x < BS; x++)
                  older[x][cmp_tag] <= 1'b0;
            end else begin
               err <= 1'b1;
            end
         end
         if (alloc) begin
            st[aidx]    <= WAIT;
            older[aidx] <= live & ~cmp_mask;
         end
         occ <= occ + (TW+1)'(alloc) - (TW+1)'(cmp_ok);
      end
   end

   // payload written on allocation only
   always_ff @(posedge clk) begin
      if (alloc && !rst) begin
         ins[aidx] <= in_instr;
         fld[aidx] <= decode(in_instr, in_regwr, in_alusrc);
      end
   end

endmodule

// File: tb/tb_esm_issue_queue.sv
// Bench for esm_issue_queue: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_esm_issue_queue;

   localparam int IW = 32;
   localparam int BS = 16;
   localparam int ISSUE_W = 2;
   localparam int TW = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [IW-1:0]         in_instr = '0;
   logic                  in_regwr = 1'b0;
   logic                  in_alusrc = 1'b0;
   logic [ISSUE_W-1:0]    iss_valid;
   logic [ISSUE_W-1:0]    iss_ready = '0;
   logic [ISSUE_W*IW-1:0] iss_instr;
   logic [ISSUE_W*TW-1:0] iss_tag;
   logic                  cmp_valid = 1'b0;
   logic [TW-1:0]         cmp_tag = '0;
   logic [TW:0]           occupancy;
   logic                  err;

   esm_issue_queue #(
      .IW (IW), .BS (BS), .REGNUM (16), .ISSUE_W (ISSUE_W)
   ) dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_instr (in_instr), .in_regwr (in_regwr),
      .in_alusrc (in_alusrc),
      .iss_valid (iss_valid), .iss_ready (iss_ready),
      .iss_instr (iss_instr), .iss_tag (iss_tag),
      .cmp_valid (cmp_valid), .cmp_tag (cmp_tag),
      .occupancy (occupancy), .err (err)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int bad = 0;

   // model: 0 free, 1 waiting, 2 issued; age by allocation sequence
   int          m_st  [BS];
   logic [31:0] m_ins [BS];
   bit          m_rw  [BS];
   bit          m_as  [BS];
   longint      m_seq [BS];
   longint      seqc = 0;
   bit          m_err = 0;

   logic [ISSUE_W-1:0]    ev;
   logic [ISSUE_W*TW-1:0] et;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit conf(int j, int i);
      int rdj, s1j, s2j, rdi, s1i, s2i;
      bit raw, war, waw;
      rdj = int'(m_ins[j][10:7]);
      s1j = int'(m_ins[j][18:15]);
      s2j = int'(m_ins[j][23:20]);
      rdi = int'(m_ins[i][10:7]);
      s1i = int'(m_ins[i][18:15]);
      s2i = int'(m_ins[i][23:20]);
      raw = m_rw[j] && (rdj == s1i || (!m_as[i] && rdj == s2i));
      war = m_rw[i] && (rdi == s1j || (!m_as[j] && rdi == s2j));
      waw = m_rw[j] && m_rw[i] && rdj == rdi;
      return raw || war || waw;
   endfunction

   function automatic bit blocked(int i);
      for (int j = 0; j < BS; j++)
         if (m_st[j] != 0 && m_seq[j] < m_seq[i] && conf(j, i))
            return 1;
      return 0;
   endfunction

   function automatic int nlive();
      int n = 0;
      for (int i = 0; i < BS; i++)
         if (m_st[i] != 0) n++;
      return n;
   endfunction

   task automatic check();
      logic [ISSUE_W*IW-1:0] ei;
      int n = 0;
      ev = '0; et = '0; ei = '0;
      for (int i = 0; i < BS; i++)
         if (m_st[i] == 1 && !blocked(i) && n < ISSUE_W) begin
            ev[n] = 1'b1;
            et[n*TW +: TW] = 4'(i);
            ei[n*IW +: IW] = m_ins[i];
            n++;
         end
      chk("iss_valid", 64'(iss_valid), 64'(ev));
      chk("iss_tag", 64'(iss_tag), 64'(et));
      chk("iss_instr", iss_instr, ei);
      chk("occupancy", 64'(occupancy), 64'(nlive()));
      chk("in_ready", 64'(in_ready), 64'(nlive() < BS));
      chk("err", 64'(err), 64'(m_err));
   endtask

   task automatic step(input bit v, input logic [31:0] ins,
                       input bit rw, input bit as,
                       input logic [1:0] ir, input bit cv,
                       input int ct, input bit r);
      int ai;
      bit cmp_hit;
      check();
      rst = r; in_valid = v; in_instr = ins;
      in_regwr = rw; in_alusrc = as; iss_ready = ir;
      cmp_valid = cv; cmp_tag = 4'(ct);
      if (r) begin
         for (int i = 0; i < BS; i++) m_st[i] = 0;
         m_err = 0;
      end else begin
         ai = -1;
         if (v && nlive() < BS)
            for (int i = BS - 1; i >= 0; i--)
               if (m_st[i] == 0) ai = i;
         cmp_hit = cv && m_st[ct] == 2;
         for (int k = 0; k < ISSUE_W; k++)
            if (ev[k] && ir[k]) m_st[int'(et[k*TW +: TW])] = 2;
         if (cv) begin
            if (cmp_hit) m_st[ct] = 0;
            else m_err = 1;
         end
         if (ai >= 0) begin
            m_st[ai] = 1; m_ins[ai] = ins;
            m_rw[ai] = rw; m_as[ai] = as;
            m_seq[ai] = seqc++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] mk(int rd, int rs1, int rs2);
      logic [31:0] w;
      w = $urandom;
      w[11:7]  = 5'(rd);
      w[19:15] = 5'(rs1);
      w[24:20] = 5'(rs2);
      return w;
   endfunction

   task automatic idle(input logic [1:0] ir);
      step(0, '0, 0, 0, ir, 0, 0, 0);
   endtask

   task automatic do_rst();
      step(0, '0, 0, 0, 2'b00, 0, 0, 1);
   endtask

   int q [$];

   initial begin
      for (int i = 0; i < BS; i++) begin
         m_st[i] = 0; m_seq[i] = 0; m_ins[i] = '0;
         m_rw[i] = 0; m_as[i] = 0;
      end
      @(negedge clk);
      do_rst();
      // 1: single instruction round trip
      chk("t1_rst_occ", 64'(occupancy), 0);
      chk("t1_rst_ready", 64'(in_ready), 1);
      chk("t1_rst_valid", 64'(iss_valid), 0);
      step(1, mk(1, 2, 3), 1, 0, 2'b00, 0, 0, 0);
      chk("t1_valid", 64'(iss_valid), 64'(2'b01));
      chk("t1_tag0", 64'(iss_tag[3:0]), 0);
      chk("t1_occ", 64'(occupancy), 1);
      idle(2'b01);
      step(0, '0, 0, 0, 2'b00, 1, 0, 0);
      chk("t1_occ_done", 64'(occupancy), 0);
      // 2: RAW dependency
      do_rst();
      step(1, mk(1, 2, 3), 1, 0, 2'b00, 0, 0, 0);
      step(1, mk(4, 1, 5), 1, 0, 2'b01, 0, 0, 0);
      chk("t2_blocked", 64'(iss_valid), 0);
      step(0, '0, 0, 0, 2'b00, 1, 0, 0);
      chk("t2_valid", 64'(iss_valid), 64'(2'b01));
      chk("t2_tag", 64'(iss_tag[3:0]), 1);
      // 3: independent dual issue
      do_rst();
      step(1, mk(1, 4, 5), 1, 0, 2'b00, 0, 0, 0);
      step(1, mk(2, 6, 7), 1, 0, 2'b00, 0, 0, 0);
      step(1, mk(3, 8, 9), 1, 0, 2'b00, 0, 0, 0);
      chk("t3_valid2", 64'(iss_valid), 64'(2'b11));
      chk("t3_tags", 64'(iss_tag), 64'(8'h10));
      idle(2'b11);
      chk("t3_valid1", 64'(iss_valid), 64'(2'b01));
      chk("t3_tag2", 64'(iss_tag[3:0]), 2);
      // 4: WAR then WAW
      do_rst();
      step(1, mk(2, 1, 0), 1, 1, 2'b00, 0, 0, 0);
      step(1, mk(1, 3, 0), 1, 1, 2'b01, 0, 0, 0);
      step(1, mk(1, 4, 0), 1, 1, 2'b00, 0, 0, 0);
      chk("t4_held", 64'(iss_valid), 0);
      step(0, '0, 0, 0, 2'b00, 1, 0, 0);
      chk("t4_e1", 64'(iss_tag[3:0]), 1);
      idle(2'b01);
      chk("t4_e2_held", 64'(iss_valid), 0);
      // 5: full buffer and same-cycle completion
      do_rst();
      for (int i = 0; i < BS; i++)
         step(1, mk(i, i, i), 0, 1, 2'b11, 0, 0, 0);
      for (int i = 0; i < 3; i++) idle(2'b11);
      chk("t5_ready0", 64'(in_ready), 0);
      chk("t5_occ16", 64'(occupancy), 16);
      step(1, mk(9, 9, 9), 0, 1, 2'b00, 1, 5, 0);
      chk("t5_occ15", 64'(occupancy), 15);
      step(1, mk(9, 9, 9), 0, 1, 2'b00, 0, 0, 0);
      chk("t5_tag5", 64'(iss_tag[3:0]), 5);
      idle(2'b00);
      chk("t5_reoffer", 64'(iss_valid), 64'(2'b01));
      // 6: error and mid-stream reset
      do_rst();
      step(0, '0, 0, 0, 2'b00, 1, 3, 0);
      chk("t6_err", 64'(err), 1);
      idle(2'b00);
      chk("t6_sticky", 64'(err), 1);
      for (int i = 0; i < 7; i++)
         step(1, mk(i, 7, 8), 1, 0, 2'b01, 0, 0, 0);
      do_rst();
      chk("t6_occ", 64'(occupancy), 0);
      chk("t6_valid", 64'(iss_valid), 0);
      chk("t6_errclr", 64'(err), 0);
      // random traffic
      for (int c = 0; c < 4000; c++) begin
         int rd, s1, s2, ct;
         bit cv;
         rd = $urandom_range(0, 7) | ($urandom_range(0, 1) << 4);
         s1 = $urandom_range(0, 7) | ($urandom_range(0, 1) << 4);
         s2 = $urandom_range(0, 7) | ($urandom_range(0, 1) << 4);
         q.delete();
         for (int i = 0; i < BS; i++)
            if (m_st[i] == 2) q.push_back(i);
         cv = ($urandom_range(0, 9) < 6);
         if (q.size() > 0 && $urandom_range(0, 9) != 0)
            ct = q[$urandom_range(0, q.size() - 1)];
         else
            ct = $urandom_range(0, BS - 1);
         step($urandom_range(0, 9) < 7, mk(rd, s1, s2),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              2'($urandom), cv, ct, $urandom_range(0, 199) == 0);
      end
      check();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
